// File: rtl/niosii_system_drum_in.sv
// niosii_system_drum_in: 4-bit drum-pad input port with edge capture, IRQ mask and level IRQ (Avalon-MM slave).
// Define DRUM_IN_DEBOUNCE_EN to enable the per-bit DEBOUNCE_CYCLES debounce filter.
module niosii_system_drum_in #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic [3:0]  in_port,
   output logic [31:0] readdata,
   output logic        irq
);

   logic [3:0] sync1_q, sync2_q;
   logic [3:0] stable_q, stable_d;
   logic [3:0] stable_dly_q;
   logic [3:0] irq_mask_q, irq_mask_d;
   logic [3:0] edge_capture_q, edge_capture_d;
   logic       irq_q, irq_d;
   logic       wr_en;
   logic [3:0] clr_bits;
   logic [3:0] rise;
   logic       unused_wdata;

   assign unused_wdata = ^writedata[31:4];

`ifdef DRUM_IN_DEBOUNCE_EN
   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0] cnt_q [4];
   logic [15:0] cnt_d [4];

   // A bit's counter only runs while sync_in disagrees with the accepted level.
   always_comb begin
      stable_d = stable_q;
      for (int unsigned i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end
`else
   localparam int unsigned UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

   always_comb begin
      stable_d = sync2_q;
   end
`endif

   assign wr_en = chipselect & ~write_n;
   assign rise  = stable_q & ~stable_dly_q;

   // A clear and a new rise in the same cycle leave the bit set.
   always_comb begin
      clr_bits       = (wr_en && address == 2'd3) ? writedata[3:0] : '0;
      irq_mask_d     = (wr_en && address == 2'd2) ? writedata[3:0] : irq_mask_q;
      edge_capture_d = (edge_capture_q & ~clr_bits) | rise;
      irq_d          = |(edge_capture_q & irq_mask_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         stable_q       <= '0;
         stable_dly_q   <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         irq_q          <= 1'b0;
      end else begin
         sync1_q        <= in_port;
         sync2_q        <= sync1_q;
         stable_q       <= stable_d;
         stable_dly_q   <= stable_q;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         irq_q          <= irq_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[3:0] = stable_q;
         2'd2:    readdata[3:0] = irq_mask_q;
         2'd3:    readdata[3:0] = edge_capture_q;
         default: readdata     = '0;
      endcase
   end

   assign irq = irq_q;

endmodule
